// File: rtl/tisc_mc_datapath.sv
// Multi-cycle TISC datapath: PC, IR, 16-entry register file with hardwired r0, ALU,
// and a FETCH/DECODE/EXECUTE/MEM/WB/HALT phase FSM with a data-memory handshake.
module tisc_mc_datapath #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_valid,
   output logic [3:0]        opcode,
   input  logic [1:0]        alu_sel,
   input  logic              reg_write_en,
   input  logic              mem_write_en,
   input  logic              mem_to_reg,
   input  logic              mem_op,
   input  logic              branch_en,
   input  logic              halt_en,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              zero_flag,
   output logic              halted,
   output logic [2:0]        phase
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } phase_t;

   phase_t            r_phase;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_ir;
   logic [DATA_W-1:0] r_a, r_b, r_aluout, r_mdr;
   logic              r_zero, r_dmem_req, r_dmem_we, r_halted;
   logic [1:0]        r_alu_sel;
   logic              r_reg_write_en, r_mem_write_en, r_mem_to_reg, r_mem_op, r_branch_en;

   logic [3:0]        w_rd, w_rs1, w_rs2;
   logic [ADDR_W-1:0] w_imm;
   logic [DATA_W-1:0] w_regs [16];
   logic [DATA_W-1:0] w_port1, w_port2, w_alu_y, w_wb_data;
   logic              w_reg_we;

   assign w_rd  = r_ir[11:8];
   assign w_rs1 = r_ir[7:4];
   assign w_rs2 = r_ir[3:0];
   assign w_imm = ADDR_W'(r_ir[7:0]);

   // Stores and branches test R[rd], so it is steered onto port 1 for them.
   assign w_port1 = ((mem_op & ~mem_to_reg) | branch_en) ? w_regs[w_rd] : w_regs[w_rs1];
   assign w_port2 = w_regs[w_rs2];

   always_comb begin
      w_alu_y = '0;
      case (r_alu_sel)
         2'b00:   w_alu_y = r_a + r_b;
         2'b01:   w_alu_y = r_a + ~r_b + DATA_W'(1);
         2'b10:   w_alu_y = r_a & r_b;
         default: w_alu_y = r_a | r_b;
      endcase
   end

   assign w_wb_data = r_mem_to_reg ? r_mdr : r_aluout;
   assign w_reg_we  = (r_phase == S_WB) && r_reg_write_en;

   assign w_regs[0] = '0;
   for (genvar gi = 1; gi < 16; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk) begin
         if (rst)
            r_q <= '0;
         else if (w_reg_we && (w_rd == 4'(gi)))
            r_q <= w_wb_data;
      end
      assign w_regs[gi] = r_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase        <= S_FETCH;
         r_pc           <= RESET_PC;
         r_ir           <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_aluout       <= '0;
         r_mdr          <= '0;
         r_zero         <= 1'b0;
         r_dmem_req     <= 1'b0;
         r_dmem_we      <= 1'b0;
         r_halted       <= 1'b0;
         r_alu_sel      <= '0;
         r_reg_write_en <= 1'b0;
         r_mem_write_en <= 1'b0;
         r_mem_to_reg   <= 1'b0;
         r_mem_op       <= 1'b0;
         r_branch_en    <= 1'b0;
      end else begin
         case (r_phase)
            S_FETCH: begin
               if (imem_valid) begin
                  r_ir    <= imem_rdata;
                  r_phase <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_alu_sel      <= alu_sel;
               r_reg_write_en <= reg_write_en;
               r_mem_write_en <= mem_write_en;
               r_mem_to_reg   <= mem_to_reg;
               r_mem_op       <= mem_op;
               r_branch_en    <= branch_en;
               r_a            <= w_port1;
               r_b            <= w_port2;
               if (halt_en) begin
                  r_halted <= 1'b1;
                  r_phase  <= S_HALT;
               end else begin
                  r_phase  <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               r_aluout <= w_alu_y;
               if (!r_mem_op && !r_branch_en)
                  r_zero <= (w_alu_y == '0);
               if (r_mem_op) begin
                  r_dmem_req <= 1'b1;
                  r_dmem_we  <= r_mem_write_en & ~r_mem_to_reg;
                  r_phase    <= S_MEM;
               end else begin
                  r_phase    <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_mdr      <= dmem_rdata;
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  r_phase    <= S_WB;
               end
            end
            S_WB: begin
               r_pc    <= (r_branch_en && (r_a == '0)) ? w_imm : r_pc + ADDR_W'(1);
               r_phase <= S_FETCH;
            end
            S_HALT: r_phase <= S_HALT;
            default: r_phase <= S_FETCH;
         endcase
      end
   end

   assign imem_addr  = r_pc;
   assign opcode     = r_ir[15:12];
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = w_imm;
   assign dmem_wdata = r_a;
   assign zero_flag  = r_zero;
   assign halted     = r_halted;
   assign phase      = r_phase;

endmodule

// File: tb/tb_tisc_mc_datapath.sv
// Bench acting as instruction memory, control unit and data memory for tisc_mc_datapath,
// checked against an instruction-level model of registers, PC, zero flag and memory.
module tb_tisc_mc_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic [3:0]  opcode;
   logic [1:0]  alu_sel;
   logic        reg_write_en, mem_write_en, mem_to_reg, mem_op, branch_en, halt_en;
   logic        dmem_req, dmem_we;
   logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ready;
   logic        zero_flag, halted;
   logic [2:0]  phase;

   int n_chk = 0;
   int n_err = 0;
   int m_r   [16];
   int m_mem [256];
   int m_pc;
   int m_zf;

   tisc_mc_datapath #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .opcode(opcode), .alu_sel(alu_sel),
      .reg_write_en(reg_write_en), .mem_write_en(mem_write_en), .mem_to_reg(mem_to_reg),
      .mem_op(mem_op), .branch_en(branch_en), .halt_en(halt_en), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .zero_flag(zero_flag),
      .halted(halted), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h want 0x%0h (pc model 0x%0h)", tag, obs, exp, m_pc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Control strobes and data-memory inputs outside their window must not matter.
   task automatic scramble();
      alu_sel      = 2'($urandom);
      reg_write_en = 1'($urandom);
      mem_write_en = 1'($urandom);
      mem_to_reg   = 1'($urandom);
      mem_op       = 1'($urandom);
      branch_en    = 1'($urandom);
      halt_en      = 1'($urandom);
      dmem_ready   = 1'($urandom);
      dmem_rdata   = 8'($urandom);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      m_pc = 0;
      m_zf = 0;
   endtask

   // Opcode map used by this bench's control unit: 0-3 ALU (alu_sel=op), 4 load,
   // 5 store, 6 branch-if-zero, anything else halt.
   task automatic run_instr(input logic [15:0] ins, input int fst, input int mw, input bit abort);
      int op, rd, rs1, rs2, imm, a, b, y;
      op  = int'(ins[15:12]);
      rd  = int'(ins[11:8]);
      rs1 = int'(ins[7:4]);
      rs2 = int'(ins[3:0]);
      imm = int'(ins[7:0]);

      chk("ph_fetch", phase, 0);
      chk("imem_addr", imem_addr, m_pc);
      for (int i = 0; i < fst; i++) begin
         imem_valid = 1'b0;
         imem_rdata = 16'($urandom);
         scramble();
         tick();
         chk("ph_stall", phase, 0);
      end
      imem_valid = 1'b1;
      imem_rdata = ins;
      scramble();
      tick();
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      chk("ph_decode", phase, 1);
      chk("opcode", opcode, op);

      alu_sel = 2'($urandom); reg_write_en = 0; mem_write_en = 0; mem_to_reg = 0;
      mem_op = 0; branch_en = 0; halt_en = 0;
      if (op < 4) begin
         alu_sel = 2'(op); reg_write_en = 1;
      end else if (op == 4) begin
         mem_op = 1; mem_to_reg = 1; reg_write_en = 1;
      end else if (op == 5) begin
         mem_op = 1; mem_write_en = 1;
      end else if (op == 6) begin
         branch_en = 1;
      end else begin
         halt_en = 1;
      end
      dmem_ready = 1'($urandom);
      tick();

      if (op > 6) begin
         chk("ph_halt", phase, 5);
         chk("halted", halted, 1);
         for (int i = 0; i < 20; i++) begin
            scramble();
            imem_valid = 1'($urandom);
            tick();
            chk("halt_pc", imem_addr, m_pc);
            chk("halt_req", dmem_req, 0);
            chk("halt_ph", phase, 5);
         end
         return;
      end

      chk("ph_exec", phase, 2);
      scramble();
      tick();

      if (op == 4 || op == 5) begin
         for (int i = 0; i <= mw; i++) begin
            chk("ph_mem", phase, 3);
            chk("dmem_req", dmem_req, 1);
            chk("dmem_we", dmem_we, (op == 5) ? 1 : 0);
            chk("dmem_addr", dmem_addr, imm);
            if (op == 5) chk("dmem_wdata", dmem_wdata, m_r[rd]);
            scramble();
            if (abort) begin
               dmem_ready = 1'b0;
               rst = 1'b1;
               tick();
               rst = 1'b0;
               model_reset();
               chk("rst_ph", phase, 0);
               chk("rst_pc", imem_addr, 0);
               chk("rst_req", dmem_req, 0);
               chk("rst_we", dmem_we, 0);
               chk("rst_zf", zero_flag, 0);
               chk("rst_halted", halted, 0);
               return;
            end
            dmem_ready = (i == mw);
            dmem_rdata = (i == mw) ? 8'(m_mem[imm]) : 8'($urandom);
            tick();
         end
      end
      chk("ph_wb", phase, 4);
      scramble();
      tick();

      if (op < 4) begin
         a = m_r[rs1];
         b = m_r[rs2];
         case (op)
            0:       y = a + b;
            1:       y = a - b;
            2:       y = a & b;
            default: y = a | b;
         endcase
         y = y & 255;
         m_zf = (y == 0) ? 1 : 0;
         if (rd != 0) m_r[rd] = y;
         m_pc = (m_pc + 1) % 256;
      end else if (op == 4) begin
         if (rd != 0) m_r[rd] = m_mem[imm];
         m_pc = (m_pc + 1) % 256;
      end else if (op == 5) begin
         m_mem[imm] = m_r[rd];
         m_pc = (m_pc + 1) % 256;
      end else begin
         m_pc = (m_r[rd] == 0) ? imm : (m_pc + 1) % 256;
      end
      chk("zero_flag", zero_flag, m_zf);
   endtask

   // Directed program: loads, add, sub-to-zero, r0 write, stores with waits,
   // branch taken / not taken, branch to 0xFF and wrap.
   logic [15:0] prog_ins [17] = '{
      16'h4110, 16'h4211, 16'h0312, 16'h5320, 16'h4712, 16'h4812, 16'h1478, 16'h0078,
      16'h5040, 16'h5440, 16'h4640, 16'h5621, 16'h6520, 16'h4513, 16'h6520, 16'h60FF,
      16'h0312 };
   int prog_fst [17] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
   int prog_mw  [17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2, 0, 0, 0};

   initial begin
      rst = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = '0;
      scramble();
      for (int i = 0; i < 256; i++) m_mem[i] = int'($urandom_range(0, 255));
      m_mem[8'h10] = 8'h05;
      m_mem[8'h11] = 8'hFC;
      m_mem[8'h12] = 8'h7A;
      m_mem[8'h13] = 8'h01;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      chk("reset_ph", phase, 0);
      chk("reset_pc", imem_addr, 0);
      chk("reset_zf", zero_flag, 0);
      chk("reset_req", dmem_req, 0);
      chk("reset_halted", halted, 0);
      chk("reset_opcode", opcode, 0);

      for (int i = 0; i < 17; i++)
         run_instr(prog_ins[i], prog_fst[i], prog_mw[i], 1'b0);

      for (int i = 0; i < 200; i++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         ins[15:12] = 4'($urandom_range(0, 6));
         run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
      end

      run_instr(16'h4910, 0, 3, 1'b1);
      run_instr(16'h4910, 0, 0, 1'b0);
      run_instr(16'h5900, 0, 1, 1'b0);
      run_instr(16'h7000, 2, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/tisc_mc_datapath.md
Name: tisc_mc_datapath

Overview:
Parametrised multi-cycle TISC datapath built around an explicit phase FSM: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- Contains the 16-entry register file, ALU, PC and instruction register; instruction and data memories are external.
- Takes control strobes from the control unit, which decodes `opcode`, and adds a data-memory handshake, branch-if-zero, halt, synchronous reset and a hardwired-zero r0.

Parameters:
DATA_W, 8, register/ALU/data-memory word width (≥4).
ADDR_W, 8, PC and data-memory address width (≥8); 8-bit immediate is zero-extended to ADDR_W.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_addr  out  ADDR_W  instruction address, equals PC
imem_rdata  in  16  instruction word
imem_valid  in  1  imem_rdata valid this cycle
opcode  out  4  IR[15:12], to control unit
alu_sel  in  2  00 add, 01 sub, 10 and, 11 or
reg_write_en  in  1  write rd in WB
mem_write_en  in  1  store (with mem_op)
mem_to_reg  in  1  WB data from memory (load)
mem_op  in  1  instruction accesses data memory
branch_en  in  1  branch if R[rd]==0 to imm
halt_en  in  1  enter HALT
dmem_req  out  1  data-memory request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  zero-extended IR[7:0]
dmem_wdata  out  DATA_W  R[rd]
dmem_rdata  in  DATA_W  load data, valid with dmem_ready
dmem_ready  in  1  access completes this cycle
zero_flag  out  1  last ALU result == 0
halted  out  1  FSM in HALT
phase  out  3  FETCH 0, DECODE 1, EXECUTE 2, MEM 3, WB 4, HALT 5

Behaviour:
- Instruction fields: rd = IR[11:8], rs1 = IR[7:4], rs2 = IR[3:0], imm = IR[7:0].
- Reset (rst high at edge, any phase, including mid MEM wait):
  - PC=RESET_PC, IR=0, phase=FETCH, all registers=0, zero_flag=0.
  - dmem_req=0, dmem_we=0, halted=0.
  - Any pending memory access is abandoned.
- FETCH: imem_addr=PC. When imem_valid=1, latch IR and go to DECODE; otherwise stay.
- DECODE:
  - opcode is valid.
  - Latch alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op, branch_en, halt_en into a control register held for the rest of the instruction.
  - Read operands:
    - port1 = R[rd] when (mem_op & ~mem_to_reg) or branch_en, else R[rs1];
    - port2 = R[rs2].
  - Latch both operands into A/B.
  - If halt_en, go to HALT; else go to EXECUTE.
- EXECUTE:
  - Y = A op B, truncated to DATA_W; sub is A + ~B + 1 mod 2^DATA_W.
  - Latch Y into ALUOUT; zero_flag <= (Y==0) for ALU-class instructions only (not mem_op, not branch_en).
  - Next phase: MEM if mem_op, else WB.
- MEM:
  - dmem_req=1 and dmem_we=mem_write_en&~mem_to_reg, both held stable while waiting.
  - dmem_addr = imm zero-extended; dmem_wdata = A.
  - Stay in MEM until dmem_ready=1, then latch dmem_rdata into MDR and go to WB.
  - dmem_ready outside MEM is ignored.
- WB:
  - If reg_write_en and rd≠0: R[rd] <= mem_to_reg ? MDR : ALUOUT.
  - Writes to r0 are discarded; r0 always reads 0.
  - PC <= (branch_en & A==0) ? imm zero-extended : PC+1 mod 2^ADDR_W.
  - Next phase: FETCH.
- HALT:
  - Terminal: PC frozen, no writes, dmem_req=0, halted=1.
  - Left only by rst.
- Latency with zero wait:
  - ALU/branch instruction: 4 cycles.
  - Load/store: 5 cycles, plus 1 per dmem_ready-low cycle in MEM and 1 per imem_valid-low cycle in FETCH.
- Register read is combinational off the DECODE-phase IR; register write occurs only in WB, so no same-instruction hazard exists.
- PC wraps 2^ADDR_W-1 -> 0 without error. A branch to the current PC is legal (spin loop).
- Control inputs outside DECODE have no effect.

Test Plan:
1. Reset then add (DATA_W=8):
   - Stimulus: rst 2 cycles; regs preloaded via loads R1=0x05, R2=0xFC; instr 0x0312 with alu_sel=00, reg_write_en=1.
   - Response: R3=0x01 after 4 cycles; zero_flag=0; PC +1.
2. Sub to zero, r0 write:
   - Stimulus: R1=R2=0x7A, sub into r4; then add into r0.
   - Response: R4=0x00 and zero_flag=1; r0 still reads 0.
3. Store then load with waits:
   - Stimulus: store R3=0xA5 to addr 0x40 with dmem_ready low 3 cycles; then load 0x40 into R6.
   - Response: dmem_req/we/addr/wdata (1/1/0x40/0xA5) held 4 cycles; R6=0xA5; each instruction takes 8 and 5 cycles respectively.
4. Branch taken and not taken:
   - Stimulus: branch_en with R5=0, imm=0x20.
   - Response: PC=0x20; repeat with R5=0x01 gives PC=old+1.
5. Halt plus stall:
   - Stimulus: imem_valid low 2 cycles in FETCH, then a halt instruction.
   - Response: phase stays 0 for 2 cycles; then halted=1, PC frozen for 20 cycles, dmem_req=0.
6. Reset mid-MEM and PC wrap:
   - Stimulus: assert rst while in MEM with dmem_ready=0.
   - Response: next cycle phase=FETCH, PC=RESET_PC, dmem_req=0; with PC=0xFF an ALU instruction yields PC=0x00.
